// File: rtl/mdf_alu_pkg.sv
// Shared constants and state codes for the multi-cycle multiply unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mdf_alu_pkg;

    localparam int WIDTH   = 32;
    localparam int STATE_W = 3;
    localparam int LANE_W  = 8;

    // Sequencer state codes. Codes 6 and 7 are never produced and recover to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CALC0 = 3'd1,
        CALC1 = 3'd2,
        CALC2 = 3'd3,
        CALC3 = 3'd4,
        DONE  = 3'd5
    } mdfState_t;

endpackage

// File: rtl/mdf_alu_state.sv
// Sequencer for the multiply unit: IDLE -> CALC0..CALC3 -> DONE -> IDLE.
// Latency: four calculation cycles after the accept edge, then DONE until accepted.
// Backpressure: holds DONE while resultAC is low; inEN is only honoured in IDLE.
module mdf_state
    import mdf_alu_pkg::*;
(
    input  logic               clk,
    input  logic               nRST,
    input  logic               inEN,
    input  logic               resultAC,
    output logic [STATE_W-1:0] stateOut,
    output logic               finished
);

    // Kept as plain bits so an illegal code can still be decoded and recovered from.
    logic [STATE_W-1:0] stateQ;
    logic [STATE_W-1:0] nextState;

    // State register plus a registered DONE decode so finished never glitches.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            stateQ   <= IDLE;
            finished <= 1'b0;
        end else begin
            stateQ   <= nextState;
            finished <= (nextState == DONE);
        end
    end

    // Next-state selection; anything unrecognised falls back to IDLE.
    always_comb begin
        nextState = IDLE;
        case (stateQ)
            IDLE:    nextState = inEN ? CALC0 : IDLE;
            CALC0:   nextState = CALC1;
            CALC1:   nextState = CALC2;
            CALC2:   nextState = CALC3;
            CALC3:   nextState = DONE;
            DONE:    nextState = resultAC ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end

    assign stateOut = stateQ;

endmodule

// File: rtl/mdf_alu.sv
// 32x32 multiply (low 32 bits) built from four 32x8 partial products, one per cycle.
// Latency: result and finished appear on the fourth edge after the accept edge.
// Backpressure: result is held in DONE until resultAC; no new issue while busy or done.
module mdf_alu
    import mdf_alu_pkg::*;
(
    input  logic               clk,
    input  logic               nRST,
    input  logic               inEN,
    input  logic               resultAC,
    input  logic [WIDTH-1:0]   dataIn1,
    input  logic [WIDTH-1:0]   dataIn2,
    output logic [WIDTH-1:0]   result,
    output logic [STATE_W-1:0] stateOut,
    output logic               finished
);

    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [WIDTH-1:0]  acc;
    logic [LANE_W-1:0] laneByte;
    logic [4:0]        laneShift;
    logic [WIDTH-1:0]  partial;
    logic [WIDTH-1:0]  accSum;

    mdf_state uState (
        .clk      (clk),
        .nRST     (nRST),
        .inEN     (inEN),
        .resultAC (resultAC),
        .stateOut (stateOut),
        .finished (finished)
    );

    // Pick the multiplier byte and its weight for the current calculation step.
    always_comb begin
        laneByte  = '0;
        laneShift = '0;
        case (stateOut)
            CALC0: begin laneByte = opB[7:0];   laneShift = 5'd0;  end
            CALC1: begin laneByte = opB[15:8];  laneShift = 5'd8;  end
            CALC2: begin laneByte = opB[23:16]; laneShift = 5'd16; end
            CALC3: begin laneByte = opB[31:24]; laneShift = 5'd24; end
            default: begin laneByte = '0; laneShift = '0; end
        endcase
    end

    // Unsigned partial product; bits above WIDTH are dropped, which keeps the
    // low half identical to the signed product.
    assign partial = (opA * {{(WIDTH-LANE_W){1'b0}}, laneByte}) << laneShift;
    assign accSum  = acc + partial;

    // Operand latches, accumulator and result register, steered by the sequencer state.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            opA    <= '0;
            opB    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (stateOut)
                IDLE: begin
                    if (inEN) begin
                        opA <= dataIn1;
                        opB <= dataIn2;
                        acc <= '0;
                    end
                end
                CALC0, CALC1, CALC2: acc <= accSum;
                CALC3: begin
                    acc    <= accSum;
                    result <= accSum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdf_alu.sv
// Randomised self-checking bench for mdf_alu against a plain-arithmetic product model.
// Latency: n/a.
// Backpressure: exercised by holding resultAC low in DONE for random spans.
module tb_mdf_alu;

    logic        clk = 1'b0;
    logic        nRST;
    logic        inEN;
    logic        resultAC;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [31:0] result;
    logic [2:0]  stateOut;
    logic        finished;

    int tests = 0;
    int fails = 0;

    mdf_alu dut (
        .clk      (clk),
        .nRST     (nRST),
        .inEN     (inEN),
        .resultAC (resultAC),
        .dataIn1  (dataIn1),
        .dataIn2  (dataIn2),
        .result   (result),
        .stateOut (stateOut),
        .finished (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            if (stateOut == 3'd0) break;
            tick();
        end
        check("idle_wait", {29'd0, stateOut}, 32'd0);
    endtask

    // One full operation: accept, four calc cycles, DONE held for 'hold' cycles, release.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit scramble, input logic [31:0] fixedExp, input bit useFixed);
        logic [31:0] exp;
        exp = useFixed ? fixedExp : refProduct(a, b);
        waitIdle();
        inEN     = 1'b1;
        resultAC = 1'b0;
        dataIn1  = a;
        dataIn2  = b;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("calc_state", {29'd0, stateOut}, k);
            check("calc_finished", {31'd0, finished}, 32'd0);
            if (scramble) begin
                dataIn1 = $urandom;
                dataIn2 = $urandom;
            end
        end
        tick();
        check("done_state", {29'd0, stateOut}, 32'd5);
        check("done_finished", {31'd0, finished}, 32'd1);
        check("done_result", result, exp);
        for (int h = 0; h < hold; h++) begin
            dataIn1 = $urandom;
            dataIn2 = $urandom;
            tick();
            check("hold_state", {29'd0, stateOut}, 32'd5);
            check("hold_finished", {31'd0, finished}, 32'd1);
            check("hold_result", result, exp);
        end
        inEN     = 1'b0;
        resultAC = 1'b1;
        tick();
        check("release_state", {29'd0, stateOut}, 32'd0);
        check("release_finished", {31'd0, finished}, 32'd0);
        check("idle_result_held", result, exp);
        resultAC = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        nRST     = 1'b1;
        inEN     = 1'b0;
        resultAC = 1'b0;
        dataIn1  = '0;
        dataIn2  = '0;
        tick();
        tick();
        check("reset_state", {29'd0, stateOut}, 32'd0);
        check("reset_finished", {31'd0, finished}, 32'd0);
        check("reset_result", result, 32'd0);
        nRST = 1'b0;
        tick();
        check("idle_no_issue", {29'd0, stateOut}, 32'd0);

        // Basic product, then backpressure for four cycles.
        runOp(32'd5, 32'd10, 0, 1'b0, 32'd50, 1'b1);
        runOp(32'd5, 32'd10, 4, 1'b0, 32'd50, 1'b1);

        // Wide and signed operands.
        runOp(32'hFFFF_FFFF, 32'd2, 1, 1'b0, 32'hFFFF_FFFE, 1'b1);
        runOp(32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 32'h0, 1'b0);
        runOp(32'hFFFF_FFFD, 32'd7, 0, 1'b0, 32'hFFFF_FFEB, 1'b1);

        // Operand changes after the latch edge must not leak into the result.
        runOp(32'h0000_1234, 32'h0000_0056, 2, 1'b1, 32'h0, 1'b0);

        // Random operands with random DONE hold time.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            runOp(a, b, $urandom_range(0, 3), 1'b1, 32'h0, 1'b0);
        end

        // Back-to-back: with inEN and resultAC held high the sequence repeats
        // IDLE, CALC0..CALC3, DONE, so after t edges the state is t mod 6.
        waitIdle();
        dataIn1  = 32'd5;
        dataIn2  = 32'd10;
        inEN     = 1'b1;
        resultAC = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            check("b2b_state", {29'd0, stateOut}, t % 6);
            check("b2b_finished", {31'd0, finished}, ((t % 6) == 5) ? 32'd1 : 32'd0);
            if (t >= 5) check("b2b_result", result, 32'd50);
        end
        inEN     = 1'b0;
        resultAC = 1'b1;
        waitIdle();
        resultAC = 1'b0;

        // Asynchronous reset during CALC2 clears everything immediately.
        dataIn1 = 32'd123;
        dataIn2 = 32'd456;
        inEN    = 1'b1;
        tick();
        tick();
        tick();
        check("pre_reset_state", {29'd0, stateOut}, 32'd3);
        #2;
        nRST = 1'b1;
        #1;
        check("async_state", {29'd0, stateOut}, 32'd0);
        check("async_finished", {31'd0, finished}, 32'd0);
        check("async_result", result, 32'd0);
        inEN = 1'b0;
        tick();
        nRST = 1'b0;
        tick();
        runOp(32'd77, 32'hFFFF_FFF0, 1, 1'b1, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
